// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Multiplexed seven-segment driver for NUM_GROUPS segment buses, each
//   scanning DIGITS_PER_GROUP digits in lockstep from one shadowed hex value.
//   Supports load-strobe shadowing, leading-zero blanking across all digits,
//   per-digit blink and decimal points, and selectable output polarity.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   value          4*N hex nibbles, nibble k drives digit k
//   load           captures value into the shadow register
//   blank_lz       enable leading-zero blanking
//   blink_mask     per-digit blink enable
//   dp_mask        per-digit decimal point
//   digits         per-digit select (N bits)
//   seg            7 segments per group, {g,f,e,d,c,b,a}
//   dp             decimal point per group
module seg7_scan_display #(
    parameter int NUM_GROUPS       = 2,
    parameter int DIGITS_PER_GROUP = 4,
    parameter int CLK_DIV          = 100000,
    parameter int BLINK_DIV        = 64,
    parameter int SEG_ACTIVE_LOW   = 0,
    parameter int SEL_ACTIVE_LOW   = 0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [4*NUM_GROUPS*DIGITS_PER_GROUP-1:0]   value,
    input  logic                                       load,
    input  logic                                       blank_lz,
    input  logic [NUM_GROUPS*DIGITS_PER_GROUP-1:0]     blink_mask,
    input  logic [NUM_GROUPS*DIGITS_PER_GROUP-1:0]     dp_mask,
    output logic [NUM_GROUPS*DIGITS_PER_GROUP-1:0]     digits,
    output logic [7*NUM_GROUPS-1:0]                    seg,
    output logic [NUM_GROUPS-1:0]                      dp
);
    localparam int N   = NUM_GROUPS * DIGITS_PER_GROUP;
    localparam int DPG = DIGITS_PER_GROUP;
    localparam int PW  = $clog2(CLK_DIV);
    localparam int IW  = (DPG > 1) ? $clog2(DPG) : 1;
    localparam int RW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    logic [4*N-1:0]  shadow;
    logic [PW-1:0]   presc;
    logic [IW-1:0]   idx;
    logic [RW-1:0]   rnd;
    logic            phase;
    logic            tick;
    logic            last_idx;

    assign tick     = (presc == PW'(CLK_DIV - 1));
    assign last_idx = (idx == IW'(DPG - 1));

    // Scan state: prescaler -> digit index -> round counter -> blink phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            presc  <= '0;
            idx    <= '0;
            rnd    <= '0;
            phase  <= 1'b0;
        end else begin
            if (load)
                shadow <= value;
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= last_idx ? '0 : idx + 1'b1;
                if (last_idx) begin
                    if (rnd == RW'(BLINK_DIV - 1)) begin
                        rnd   <= '0;
                        phase <= ~phase;
                    end else begin
                        rnd <= rnd + 1'b1;
                    end
                end
            end
        end
    end

    // zero_from[k]: every nibble from k up to the top is zero, so digit k is
    // a leading zero of the whole N-digit number.
    logic [N-1:0] zero_from;
    for (genvar k = 0; k < N; k++) begin : g_lz
        assign zero_from[k] = (shadow[4*N-1:4*k] == '0);
    end

    logic [N-1:0]            sel_n;
    logic [7*NUM_GROUPS-1:0] seg_n;
    logic [NUM_GROUPS-1:0]   dp_n;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        localparam int BASE = g * DPG;
        logic [4*DPG-1:0] grp_nib;
        logic [DPG-1:0]   grp_blink;
        logic [DPG-1:0]   grp_dp;
        logic [DPG-1:0]   grp_zero;
        logic [3:0]       nib;
        logic             lz_ok;
        logic             blank;

        assign grp_nib   = shadow[4*BASE +: 4*DPG];
        assign grp_blink = blink_mask[BASE +: DPG];
        assign grp_dp    = dp_mask[BASE +: DPG];
        assign grp_zero  = zero_from[BASE +: DPG];
        assign nib       = grp_nib[4*idx +: 4];
        // Global digit 0 is never blanked as a leading zero.
        assign lz_ok     = (g != 0) || (idx != '0);
        assign blank     = (blank_lz && lz_ok && grp_zero[idx]) ||
                           (grp_blink[idx] && phase);

        assign sel_n[BASE +: DPG] = DPG'(1) << idx;
        assign seg_n[7*g +: 7]    = blank ? 7'h00 : hex7(nib);
        assign dp_n[g]            = !blank && grp_dp[idx];
    end

    // Output register: polarity applied here so reset drives inactive levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits <= {N{SEL_INV}};
            seg    <= {(7*NUM_GROUPS){SEG_INV}};
            dp     <= {NUM_GROUPS{SEG_INV}};
        end else begin
            digits <= sel_n ^ {N{SEL_INV}};
            seg    <= seg_n ^ {(7*NUM_GROUPS){SEG_INV}};
            dp     <= dp_n  ^ {NUM_GROUPS{SEG_INV}};
        end
    end
endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: two instances (active-high and active-low
// polarity) share stimulus; a cycle-count model predicts every output.
module tb_seg7_scan_display;
    localparam int NG  = 2;
    localparam int DPG = 4;
    localparam int N   = NG * DPG;
    localparam int CLK = 4;
    localparam int BLK = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [4*N-1:0] value;
    logic          load, blank_lz;
    logic [N-1:0]  blink_mask, dp_mask;
    logic [N-1:0]  digits, digits_n;
    logic [7*NG-1:0] seg, seg_n;
    logic [NG-1:0] dp, dp_n;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    seg7_scan_display #(.NUM_GROUPS(NG), .DIGITS_PER_GROUP(DPG), .CLK_DIV(CLK),
        .BLINK_DIV(BLK), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
        .blink_mask(blink_mask), .dp_mask(dp_mask),
        .digits(digits), .seg(seg), .dp(dp));

    seg7_scan_display #(.NUM_GROUPS(NG), .DIGITS_PER_GROUP(DPG), .CLK_DIV(CLK),
        .BLINK_DIV(BLK), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut_inv (
        .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
        .blink_mask(blink_mask), .dp_mask(dp_mask),
        .digits(digits_n), .seg(seg_n), .dp(dp_n));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Model: outputs after edge e reflect cycle c=e-1 since reset release.
    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          c = 0;
    logic [31:0] msh = '0;
    logic [N-1:0]    e_dig = '0;
    logic [7*NG-1:0] e_seg = '0;
    logic [NG-1:0]   e_dp  = '0;
    int m_step, m_idx, m_rnd, m_ph, m_k;
    logic [31:0] m_up;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c = 0; msh = '0; e_dig = '0; e_seg = '0; e_dp = '0;
        end else begin
            m_step = c / CLK;
            m_idx  = m_step % DPG;
            m_rnd  = m_step / DPG;
            m_ph   = (m_rnd / BLK) % 2;
            e_dig = '0; e_seg = '0; e_dp = '0;
            for (int g = 0; g < NG; g++) begin
                m_k = g * DPG + m_idx;
                e_dig[m_k] = 1'b1;
                m_up = msh >> (4 * m_k);
                if (!((blank_lz && m_k > 0 && m_up == 0) || (blink_mask[m_k] && m_ph == 1))) begin
                    e_seg[7*g +: 7] = segtab[m_up[3:0]];
                    e_dp[g] = dp_mask[m_k];
                end
            end
            if (load) msh = value;
            c++;
        end
    end

    logic [N-1:0]    x_dig;
    logic [7*NG-1:0] x_seg;
    logic [NG-1:0]   x_dp;
    always @(negedge clk) begin
        x_dig = ~e_dig; x_seg = ~e_seg; x_dp = ~e_dp;
        check("model_digits", 32'(digits), 32'(e_dig));
        check("model_seg",    32'(seg),    32'(e_seg));
        check("model_dp",     32'(dp),     32'(e_dp));
        check("model_inv_digits", 32'(digits_n), 32'(x_dig));
        check("model_inv_seg",    32'(seg_n),    32'(x_seg));
        check("model_inv_dp",     32'(dp_n),     32'(x_dp));
    end

    task automatic goto_edge(input int n);
        int guard = 0;
        while (c < n && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("edge_reached", 32'(c), 32'(n));
    endtask

    task automatic rst_pulse();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_digits", 32'(digits), 32'h00);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_inv_digits", 32'(digits_n), 32'hFF);
        check("rst_inv_seg", 32'(seg_n), 32'h3FFF);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; load = 0; value = '0; blank_lz = 0; blink_mask = '0; dp_mask = '0;
        #22;
        check("por_digits", 32'(digits), 32'h00);
        check("por_seg", 32'(seg), 32'h0);
        check("por_dp", 32'(dp), 32'h0);
        check("por_inv_digits", 32'(digits_n), 32'hFF);
        check("por_inv_seg", 32'(seg_n), 32'h3FFF);
        check("por_inv_dp", 32'(dp_n), 32'h3);

        // Scan and decode
        @(negedge clk); value = 32'h89AB_0123; load = 1; rst = 0;
        goto_edge(1);  check("first_digits", 32'(digits), 32'h11); load = 0;
        goto_edge(2);  check("s0_seg", 32'(seg), 32'h3E4F); check("s0_dig", 32'(digits), 32'h11);
        goto_edge(5);  check("s1_seg", 32'(seg), 32'h3BDB); check("s1_dig", 32'(digits), 32'h22);
        goto_edge(9);  check("s2_seg", 32'(seg), 32'h3786); check("s2_dig", 32'(digits), 32'h44);
        goto_edge(13); check("s3_seg", 32'(seg), 32'h3FBF); check("s3_dig", 32'(digits), 32'h88);
        check("inv_seg8", 32'(seg_n), 32'h0040);
        goto_edge(17); check("wrap_seg", 32'(seg), 32'h3E4F); check("wrap_dig", 32'(digits), 32'h11);
        // value without load is ignored
        value = 32'h1234_5678;
        goto_edge(21); check("noload_seg", 32'(seg), 32'h3BDB);
        // load held high tracks value
        for (int i = 1; i <= 4; i++) begin
            value = 32'h1111_1111 * i; load = 1;
            goto_edge(21 + i);
        end
        load = 0;
        goto_edge(29); check("held_seg", 32'(seg), 32'h3366);

        // Leading-zero blanking
        rst_pulse();
        value = 32'h0000_00F0; load = 1; blank_lz = 1;
        @(negedge clk); rst = 0;
        goto_edge(1); load = 0;
        goto_edge(2);  check("lz_d0", 32'(seg), 32'h003F);
        goto_edge(5);  check("lz_d1", 32'(seg), 32'h0071);
        goto_edge(9);  check("lz_d2", 32'(seg), 32'h0000); check("lz_d2_dig", 32'(digits), 32'h44);
        value = 32'h0; load = 1;
        goto_edge(10); load = 0;
        goto_edge(13); check("lz0_d3", 32'(seg), 32'h0000);
        goto_edge(17); check("lz0_d0", 32'(seg), 32'h003F);
        goto_edge(21); check("lz0_d1", 32'(seg), 32'h0000);

        // Blink and decimal points
        rst_pulse();
        value = 32'h1234_5678; load = 1; blank_lz = 0; blink_mask = 8'h01; dp_mask = 8'h10;
        @(negedge clk); rst = 0;
        goto_edge(1);  check("dp_e1", 32'(dp), 32'h2); load = 0;
        goto_edge(2);  check("blk_on_seg", 32'(seg), 32'h337F); check("blk_on_dp", 32'(dp), 32'h2);
        goto_edge(5);  check("dp_off", 32'(dp), 32'h0);
        goto_edge(33); check("blk_off_seg", 32'(seg), 32'h3300); check("blk_off_dp", 32'(dp), 32'h2);
        goto_edge(49); check("blk_off2_seg", 32'(seg), 32'h3300);
        goto_edge(65); check("blk_back_seg", 32'(seg), 32'h337F);
        // load coincident with tick (cycle 67 has prescaler at CLK_DIV-1)
        goto_edge(67); value = 32'hABCD_EF00; load = 1;
        goto_edge(68); load = 0;
        goto_edge(69);
        check("tick_load_dig", 32'(digits), 32'h22);
        check("tick_load_seg", 32'(seg), 32'h1CBF);
        check("tick_load_dp", 32'(dp), 32'h0);
        goto_edge(140);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
